// File: rtl/stereo_circ_queue.sv
// Stereo circular sample queue: stores decimated L/R samples and streams
// the most recent SEQ_LEN-sample window, oldest first, to the FIR engine.
module stereo_circ_queue #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 1024,
    parameter int SEQ_LEN = 1021,
    parameter int DECIM   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrt_smpl,
    input  logic [WIDTH-1:0] lft_smpl,
    input  logic [WIDTH-1:0] rght_smpl,
    output logic [WIDTH-1:0] lft_out,
    output logic [WIDTH-1:0] rght_out,
    output logic             sequencing,
    output logic             seq_last,
    output logic             ovrn
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SEQ_LEN + 1);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LEN     = CW'(SEQ_LEN);
    localparam logic [CW-1:0] LEN_M1  = CW'(SEQ_LEN - 1);
    localparam logic [PW-1:0] PH_MAX  = PW'(DECIM - 1);
    localparam logic [OW-1:0] OVR_LIM = OW'(DEPTH - SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t state;

    logic [PW-1:0] phase;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] old_ptr;
    logic [AW-1:0] old_ptr_nxt;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rd_cnt;
    logic [OW-1:0] wcnt;
    logic          req;
    logic          valid;
    logic          last;
    logic          accept;
    logic          trig;

    logic [WIDTH-1:0] mem_l [DEPTH];
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] q_l;
    logic [WIDTH-1:0] q_r;

    always_comb begin
        accept      = wrt_smpl && (phase == '0);
        old_ptr_nxt = old_ptr;
        if (accept && (cnt == LEN)) begin
            old_ptr_nxt = old_ptr + AW'(1);
        end
        // a write that leaves the window full (or keeps it full)
        trig = accept && ((cnt == LEN) || (cnt == LEN_M1));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_l[new_ptr] <= lft_smpl;
            mem_r[new_ptr] <= rght_smpl;
        end
        q_l <= mem_l[rd_ptr];
        q_r <= mem_r[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            new_ptr <= '0;
            old_ptr <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_cnt  <= '0;
            wcnt    <= '0;
            req     <= 1'b0;
            valid   <= 1'b0;
            last    <= 1'b0;
            ovrn    <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                phase <= (phase == PH_MAX) ? '0 : phase + PW'(1);
            end
            if (accept) begin
                new_ptr <= new_ptr + AW'(1);
                old_ptr <= old_ptr_nxt;
                if (cnt != LEN) begin
                    cnt <= cnt + CW'(1);
                end
            end
            valid <= 1'b0;
            last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    req <= trig;
                    if (req) begin
                        state  <= READ;
                        rd_ptr <= old_ptr;
                        rd_cnt <= '0;
                        wcnt   <= OW'(accept);
                    end
                end
                READ: begin
                    valid  <= 1'b1;
                    rd_ptr <= rd_ptr + AW'(1);
                    rd_cnt <= rd_cnt + CW'(1);
                    if (rd_cnt == LEN_M1) begin
                        state <= DRAIN;
                        last  <= 1'b1;
                    end
                    if (trig) begin
                        req <= 1'b1;
                    end
                    if (accept) begin
                        if (wcnt != '1) begin
                            wcnt <= wcnt + OW'(1);
                        end
                        if (wcnt >= OVR_LIM) begin
                            ovrn <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // a write on this edge already counts toward the next window
                    if (req || trig) begin
                        state  <= READ;
                        rd_ptr <= old_ptr_nxt;
                        rd_cnt <= '0;
                        wcnt   <= '0;
                        req    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sequencing = valid;
    assign seq_last   = last;
    assign lft_out    = valid ? q_l : '0;
    assign rght_out   = valid ? q_r : '0;

endmodule

// File: tb/tb_stereo_circ_queue.sv
// Testbench for stereo_circ_queue: window read-out, back-to-back sequences,
// overrun, decimation and mid-sequence reset against a sample-history model.
module tb_stereo_circ_queue;

    localparam int W = 16;
    localparam int D = 16;
    localparam int L = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wrt = 1'b0;
    logic [W-1:0] lin = '0;
    logic [W-1:0] rin = '0;

    logic [W-1:0] lo1, ro1, lo2, ro2;
    logic sq1, sl1, ov1, sq2, sl2, ov2;

    always #5 clk = ~clk;

    stereo_circ_queue #(.WIDTH(W), .DEPTH(D), .SEQ_LEN(L), .DECIM(1)) dut (
        .clk(clk), .rst(rst), .wrt_smpl(wrt),
        .lft_smpl(lin), .rght_smpl(rin),
        .lft_out(lo1), .rght_out(ro1),
        .sequencing(sq1), .seq_last(sl1), .ovrn(ov1)
    );

    stereo_circ_queue #(.WIDTH(W), .DEPTH(D), .SEQ_LEN(L), .DECIM(2)) dut2 (
        .clk(clk), .rst(rst), .wrt_smpl(wrt),
        .lft_smpl(lin), .rght_smpl(rin),
        .lft_out(lo2), .rght_out(ro2),
        .sequencing(sq2), .seq_last(sl2), .ovrn(ov2)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sel = 0;
    int decim = 1;
    int wcount = 0;

    // model: every stored sample since reset
    logic [W-1:0] hl[$];
    logic [W-1:0] hr[$];
    // expected sequences
    logic [W-1:0] el[$];
    logic [W-1:0] er[$];
    int est[$];
    // observed sequences
    logic [W-1:0] ml[$];
    logic [W-1:0] mr[$];
    logic mlast[$];
    int sst[$];
    int slen[$];
    int idle_nz = 0;
    logic in_seq = 1'b0;

    logic m_s, m_t;
    logic [W-1:0] m_l, m_r;

    always @(posedge clk) begin
        #1;
        cyc++;
        m_s = sel != 0 ? sq2 : sq1;
        m_t = sel != 0 ? sl2 : sl1;
        m_l = sel != 0 ? lo2 : lo1;
        m_r = sel != 0 ? ro2 : ro1;
        if (m_s) begin
            if (!in_seq) begin
                sst.push_back(cyc);
                slen.push_back(0);
            end
            ml.push_back(m_l);
            mr.push_back(m_r);
            mlast.push_back(m_t);
            slen[slen.size()-1]++;
        end else if (m_l != '0 || m_r != '0 || m_t) begin
            idle_nz++;
        end
        in_seq = m_s;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [W-1:0] l, input logic [W-1:0] r);
        lin = l;
        rin = r;
        wrt = 1'b1;
        tick();
        wrt = 1'b0;
        if (wcount % decim == 0) begin
            hl.push_back(l);
            hr.push_back(r);
        end
        wcount++;
    endtask

    task automatic push_exp(input int st);
        int n;
        n = hl.size();
        if (n >= L) begin
            for (int i = 0; i < L; i++) begin
                el.push_back(hl[n-L+i]);
                er.push_back(hr[n-L+i]);
            end
            est.push_back(st);
        end
    endtask

    task automatic clear_log();
        ml.delete(); mr.delete(); mlast.delete();
        sst.delete(); slen.delete();
        el.delete(); er.delete(); est.delete();
        idle_nz = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hl.delete();
        hr.delete();
        wcount = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (sq1 !== 1'b0) begin
            fails++; $display("FAIL rst_seq got %b exp 0", sq1);
        end
        tests++;
        if (sl1 !== 1'b0) begin
            fails++; $display("FAIL rst_last got %b exp 0", sl1);
        end
        tests++;
        if (ov1 !== 1'b0) begin
            fails++; $display("FAIL rst_ovrn got %b exp 0", ov1);
        end
        tests++;
        if ({lo1, ro1} !== 32'd0) begin
            fails++; $display("FAIL rst_data got %h/%h exp 0/0", lo1, ro1);
        end
        tests++;
        if ({sq2, sl2, ov2, lo2, ro2} !== 35'd0) begin
            fails++; $display("FAIL rst_dut2 got %b%b%b %h/%h exp 0", sq2, sl2, ov2, lo2, ro2);
        end
    endtask

    task automatic test_fill();
        clear_log();
        for (int n = 0; n <= 10; n++) begin
            wr(W'(n), W'(256 + n));
            repeat (19) tick();
        end
        tests++;
        if (sst.size() !== 0) begin
            fails++; $display("FAIL fill_noseq got %0d seqs exp 0", sst.size());
        end
        tests++;
        if (idle_nz !== 0) begin
            fails++; $display("FAIL fill_outs0 got %0d nonzero cycles exp 0", idle_nz);
        end
    endtask

    task automatic test_first_window();
        int t;
        clear_log();
        wr(W'(11), W'(267));
        t = cyc;
        push_exp(t + 2);
        repeat (19) tick();
        tests++;
        if (sst.size() !== 1) begin
            fails++; $display("FAIL first_count got %0d exp 1", sst.size());
        end
        if (sst.size() > 0) begin
            tests++;
            if (sst[0] !== t + 2 || slen[0] !== L) begin
                fails++; $display("FAIL first_timing got %0d/%0d exp %0d/%0d", sst[0] - t, slen[0], 2, L);
            end
        end
        foreach (el[k]) if (k < ml.size()) begin
            logic xl;
            xl = (k % L) == L - 1;
            tests++;
            if ({ml[k], mr[k], mlast[k]} !== {el[k], er[k], xl}) begin
                fails++; $display("FAIL first_data[%0d] got %h/%h/%b exp %h/%h/%b", k, ml[k], mr[k], mlast[k], el[k], er[k], xl);
            end
        end
        if (ml.size() == L) begin
            tests++;
            if ({ml[0], ml[11], mr[11]} !== {16'd0, 16'd11, 16'h10b}) begin
                fails++; $display("FAIL first_ends got %h %h %h exp 0 b 10b", ml[0], ml[11], mr[11]);
            end
        end
        tests++;
        if (idle_nz !== 0) begin
            fails++; $display("FAIL first_outs0 got %0d exp 0", idle_nz);
        end
    endtask

    task automatic test_slide();
        clear_log();
        for (int n = 12; n <= 40; n++) begin
            wr(W'(n), W'(256 + n));
            push_exp(cyc + 2);
            repeat (19) tick();
        end
        tests++;
        if (sst.size() !== est.size()) begin
            fails++; $display("FAIL slide_count got %0d exp %0d", sst.size(), est.size());
        end
        foreach (est[j]) if (j < sst.size()) begin
            tests++;
            if (sst[j] !== est[j] || slen[j] !== L) begin
                fails++; $display("FAIL slide_timing[%0d] got %0d/%0d exp %0d/%0d", j, sst[j], slen[j], est[j], L);
            end
        end
        foreach (el[k]) if (k < ml.size()) begin
            logic xl;
            xl = (k % L) == L - 1;
            tests++;
            if ({ml[k], mr[k], mlast[k]} !== {el[k], er[k], xl}) begin
                fails++; $display("FAIL slide_data[%0d] got %h/%h/%b exp %h/%h/%b", k, ml[k], mr[k], mlast[k], el[k], er[k], xl);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        clear_log();
        wr(W'($urandom), W'($urandom));
        t = cyc;
        push_exp(t + 2);
        repeat (5) tick();
        wr(W'($urandom), W'($urandom));
        tick();
        wr(W'($urandom), W'($urandom));
        push_exp(t + 2 + L + 1);
        repeat (40) tick();
        tests++;
        if (sst.size() !== 2) begin
            fails++; $display("FAIL b2b_count got %0d exp 2", sst.size());
        end
        foreach (est[j]) if (j < sst.size()) begin
            tests++;
            if (sst[j] !== est[j] || slen[j] !== L) begin
                fails++; $display("FAIL b2b_timing[%0d] got %0d/%0d exp %0d/%0d", j, sst[j], slen[j], est[j], L);
            end
        end
        foreach (el[k]) if (k < ml.size()) begin
            logic xl;
            xl = (k % L) == L - 1;
            tests++;
            if ({ml[k], mr[k], mlast[k]} !== {el[k], er[k], xl}) begin
                fails++; $display("FAIL b2b_data[%0d] got %h/%h/%b exp %h/%h/%b", k, ml[k], mr[k], mlast[k], el[k], er[k], xl);
            end
        end
        tests++;
        if (ov1 !== 1'b0) begin
            fails++; $display("FAIL b2b_ovrn got %b exp 0", ov1);
        end
    endtask

    task automatic test_overrun();
        int t;
        clear_log();
        wr(W'($urandom), W'($urandom));
        t = cyc;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            wr(W'($urandom), W'($urandom));
            if (i == 2) begin
                tests++;
                if (ov1 !== 1'b0) begin
                    fails++; $display("FAIL ovrn_3rd got %b exp 0", ov1);
                end
            end
            if (i == 3) begin
                tests++;
                if (ov1 !== 1'b1) begin
                    fails++; $display("FAIL ovrn_4th got %b exp 1", ov1);
                end
            end
            tick();
        end
        repeat (40) tick();
        tests++;
        if (ov1 !== 1'b1) begin
            fails++; $display("FAIL ovrn_sticky got %b exp 1", ov1);
        end
        tests++;
        if (sst.size() !== 2) begin
            fails++; $display("FAIL ovrn_count got %0d exp 2", sst.size());
        end else begin
            tests++;
            if (sst[1] - sst[0] !== L + 1 || sst[0] !== t + 2) begin
                fails++; $display("FAIL ovrn_timing got %0d,%0d exp %0d,%0d", sst[0], sst[1], t + 2, t + L + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        tests++;
        if (ov1 !== 1'b1) begin
            fails++; $display("FAIL mid_ovrn_pre got %b exp 1", ov1);
        end
        wr(W'($urandom), W'($urandom));
        repeat (7) tick();
        tests++;
        if (sq1 !== 1'b1) begin
            fails++; $display("FAIL mid_active got %b exp 1", sq1);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({sq1, sl1, ov1, lo1, ro1} !== 35'd0) begin
            fails++; $display("FAIL mid_abort got %b%b%b %h/%h exp all 0", sq1, sl1, ov1, lo1, ro1);
        end
        rst = 1'b0;
        hl.delete();
        hr.delete();
        wcount = 0;
        clear_log();
        for (int n = 0; n < 11; n++) begin
            wr(W'($urandom), W'($urandom));
            repeat ($urandom_range(1, 4)) tick();
        end
        repeat (20) tick();
        tests++;
        if (sst.size() !== 0 || idle_nz !== 0) begin
            fails++; $display("FAIL mid_refill got %0d seqs %0d nz exp 0 0", sst.size(), idle_nz);
        end
    endtask

    task automatic test_decim();
        do_reset();
        sel = 1;
        decim = 2;
        clear_log();
        for (int n = 0; n <= 30; n++) begin
            wr(W'(n), W'(256 + n));
            if (n % 2 == 0) begin
                push_exp(cyc + 2);
            end
            repeat (19) tick();
        end
        tests++;
        if (sst.size() !== 5 || est.size() !== 5) begin
            fails++; $display("FAIL dec_count got %0d exp 5 (model %0d)", sst.size(), est.size());
        end
        foreach (est[j]) if (j < sst.size()) begin
            tests++;
            if (sst[j] !== est[j] || slen[j] !== L) begin
                fails++; $display("FAIL dec_timing[%0d] got %0d/%0d exp %0d/%0d", j, sst[j], slen[j], est[j], L);
            end
        end
        foreach (el[k]) if (k < ml.size()) begin
            logic xl;
            xl = (k % L) == L - 1;
            tests++;
            if ({ml[k], mr[k], mlast[k]} !== {el[k], er[k], xl}) begin
                fails++; $display("FAIL dec_data[%0d] got %h/%h/%b exp %h/%h/%b", k, ml[k], mr[k], mlast[k], el[k], er[k], xl);
            end
        end
        if (ml.size() >= L) begin
            tests++;
            if ({ml[0], ml[1], ml[11]} !== {16'd0, 16'd2, 16'd22}) begin
                fails++; $display("FAIL dec_first got %0d %0d %0d exp 0 2 22", ml[0], ml[1], ml[11]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_first_window();
        test_slide();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_decim();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
